// File: rtl/offchip_mem_pkg.sv
// Shared constants and helpers for the off-chip byte memory responder.
package offchip_mem_pkg;

    localparam int CH_NUM          = 2;
    localparam int MEM_DELAY_READ  = 2;
    localparam int MEM_DELAY_WRITE = 1;
    localparam int MEM_SIZE_DEF    = 32;
    localparam int SIZE_W          = 4;
    localparam int MASK_W          = 16;

    // Bit-count to low-order write mask: (1 << size) - 1.
    // Callers truncate to their data width, so any size >= DATA_W gives a full word.
    function automatic logic [MASK_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
        logic [MASK_W:0] one_hot;
        one_hot = (MASK_W+1)'(1) << size;
        return MASK_W'(one_hot - 1'b1);
    endfunction

endpackage

// File: rtl/offchip_mem_channel.sv
// One master channel: window hit decode, latency counter, read delay line, DataRdy.
module offchip_mem_channel
    import offchip_mem_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int MEMSIZE     = MEM_SIZE_DEF,
    parameter int OFF_W       = $clog2(MEMSIZE),
    parameter int READ_DELAY  = MEM_DELAY_READ,
    parameter int WRITE_DELAY = MEM_DELAY_WRITE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              oe,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              hit,
    output logic [OFF_W-1:0]  offset,
    output logic [DATA_W-1:0] rdata,
    output logic              data_rdy
);

    localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int CNT_W     = (MAX_DELAY > 2) ? $clog2(MAX_DELAY) : 1;
    localparam int RD_STAGES = READ_DELAY - 1;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_DELAY - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_DELAY - 1);
    localparam logic [ADDR_W:0]  SPAN    = (ADDR_W+1)'(MEMSIZE);

    logic [ADDR_W:0]  addr_ext;
    logic [ADDR_W:0]  lo_ext;
    logic [ADDR_W:0]  hi_ext;
    logic [CNT_W-1:0] cnt;
    logic [DATA_W-1:0] rd_pipe [RD_STAGES];

    // Window compare is done one bit wider so a window reaching the top of the
    // address space does not wrap around to low addresses.
    assign addr_ext = {1'b0, addr};
    assign lo_ext   = {1'b0, base_addr};
    assign hi_ext   = lo_ext + SPAN;
    assign hit      = (addr_ext >= lo_ext) && (addr_ext < hi_ext);
    assign offset   = OFF_W'(addr - base_addr);

    // Latency counter: counts held read (or write) cycles and wraps after the strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (oe && hit) begin
            cnt <= (cnt < RD_LAST) ? cnt + 1'b1 : '0;
        end else if (we && hit) begin
            cnt <= (cnt < WR_LAST) ? cnt + 1'b1 : '0;
        end else begin
            cnt <= '0;
        end
    end

    // Read delay line: stage 0 samples the addressed byte (0 on a miss), so a
    // same-cycle write to that byte is not visible to this read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_STAGES; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= hit ? mem_rdata : '0;
            for (int i = 1; i < RD_STAGES; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rdata    = rd_pipe[RD_STAGES-1];
    assign data_rdy = hit & ((cnt == RD_LAST) | (we & (cnt == WR_LAST)));

endmodule

// File: rtl/offchip_mem_responder.sv
// Off-chip byte memory answering the HLS master port: shared array, write
// arbitration, preload/readback side port and the sticky oe/we conflict flag.
module offchip_mem_responder
    import offchip_mem_pkg::*;
#(
    parameter int MEMSIZE     = MEM_SIZE_DEF,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int READ_DELAY  = MEM_DELAY_READ,
    parameter int WRITE_DELAY = MEM_DELAY_WRITE
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [CH_NUM-1:0]          Mout_oe_ram,
    input  logic [CH_NUM-1:0]          Mout_we_ram,
    input  logic [CH_NUM*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [CH_NUM*DATA_W-1:0]   Mout_Wdata_ram,
    input  logic [CH_NUM*SIZE_W-1:0]   Mout_data_ram_size,
    output logic [CH_NUM*DATA_W-1:0]   M_Rdata_ram,
    output logic [CH_NUM-1:0]          M_DataRdy,
    input  logic                       init_we,
    input  logic [ADDR_W-1:0]          init_addr,
    input  logic [DATA_W-1:0]          init_data,
    input  logic [ADDR_W-1:0]          dbg_addr,
    output logic [DATA_W-1:0]          dbg_rdata,
    output logic                       err_conflict
);

    localparam int OFF_W = $clog2(MEMSIZE);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEMSIZE);

    logic [DATA_W-1:0] mem [MEMSIZE];

    logic [CH_NUM-1:0] ch_hit;
    logic [OFF_W-1:0]  ch_off    [CH_NUM];
    logic [DATA_W-1:0] ch_mem    [CH_NUM];
    logic [DATA_W-1:0] ch_wr_val [CH_NUM];
    logic [CH_NUM-1:0] ch_wr_en;
    logic              init_ok;
    logic [OFF_W-1:0]  init_idx;
    logic              dbg_ok;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [DATA_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;

        assign ch_mem[c] = mem[ch_off[c]];
        assign wmask     = DATA_W'(size_mask(Mout_data_ram_size[c*SIZE_W +: SIZE_W]));
        assign wdata     = Mout_Wdata_ram[c*DATA_W +: DATA_W];

        // Masked merge against the pre-edge byte; a conflicting oe suppresses the write.
        assign ch_wr_val[c] = (wdata & wmask) | (ch_mem[c] & ~wmask);
        assign ch_wr_en[c]  = Mout_we_ram[c] & ~Mout_oe_ram[c] & ch_hit[c] & ~reset;

        offchip_mem_channel #(
            .ADDR_W      (ADDR_W),
            .DATA_W      (DATA_W),
            .MEMSIZE     (MEMSIZE),
            .OFF_W       (OFF_W),
            .READ_DELAY  (READ_DELAY),
            .WRITE_DELAY (WRITE_DELAY)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .base_addr (base_addr),
            .oe        (Mout_oe_ram[c]),
            .we        (Mout_we_ram[c]),
            .addr      (Mout_addr_ram[c*ADDR_W +: ADDR_W]),
            .mem_rdata (ch_mem[c]),
            .hit       (ch_hit[c]),
            .offset    (ch_off[c]),
            .rdata     (M_Rdata_ram[c*DATA_W +: DATA_W]),
            .data_rdy  (M_DataRdy[c])
        );
    end

    assign init_ok   = init_we & ~reset & ({1'b0, init_addr} < MEM_LIMIT);
    assign init_idx  = init_addr[OFF_W-1:0];
    assign dbg_ok    = {1'b0, dbg_addr} < MEM_LIMIT;
    assign dbg_rdata = dbg_ok ? mem[dbg_addr[OFF_W-1:0]] : '0;

    // Storage is never cleared; later assignments win, so channel writes override
    // the preload port and channel 1 overrides channel 0 on the same byte.
    always_ff @(posedge clock) begin
        if (init_ok) begin
            mem[init_idx] <= init_data;
        end
        for (int c = 0; c < CH_NUM; c++) begin
            if (ch_wr_en[c]) begin
                mem[ch_off[c]] <= ch_wr_val[c];
            end
        end
    end

    // Sticky flag for a channel driving oe and we together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_conflict <= 1'b0;
        end else if (|(Mout_oe_ram & Mout_we_ram)) begin
            err_conflict <= 1'b1;
        end
    end

endmodule
